y86_execute_unit: RTL and testbench

Sequential execute stage for the Y86-64 SEQ datapath. It sits directly downstream of decode and drives the 64-bit ALU (ADD/SUB/AND/XOR) with Y86 operand and function selection. It holds the condition-code register (ZF/SF/OF), evaluates the branch/cmov condition `Cnd`, and hands `valE`/`Cnd` to the memory stage over a valid/ready handshake.

---
 rtl/y86_execute_unit.sv | 159 +++++++++++++++
 tb/tb_y86_execute_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_execute_unit.sv
// Y86-64 SEQ execute stage: a three-state (IDLE/EXEC/DONE) unit that captures
// one decoded instruction, computes valE/Cnd/exc and the condition codes,
// and hands the result downstream.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The producer holds valid and its data stable until that edge. in_ready depends
// only on the state, and out_valid stays 1 until out_ready is seen in DONE.
module y86_execute_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] valE,
    output logic             Cnd,
    output logic [2:0]       cc,
    output logic             exc,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       icode_q;
    logic [3:0]       ifun_q;
    logic [WIDTH-1:0] vala_q;
    logic [WIDTH-1:0] valb_q;
    logic [WIDTH-1:0] valc_q;

    logic [WIDTH-1:0] res;
    logic             cond;
    logic             cnd_c;
    logic             exc_c;
    logic             of_c;
    logic             cc_we;

    assign in_ready  = (state == IDLE);
    assign fsm_state = state;

    // Condition evaluation uses the flags as they stood before this instruction.
    always_comb begin
        cond = 1'b0;
        case (ifun_q)
            4'd0: cond = 1'b1;
            4'd1: cond = (cc[1] ^ cc[0]) | cc[2];
            4'd2: cond = cc[1] ^ cc[0];
            4'd3: cond = cc[2];
            4'd4: cond = ~cc[2];
            4'd5: cond = ~(cc[1] ^ cc[0]);
            4'd6: cond = ~(cc[1] ^ cc[0]) & ~cc[2];
            default: cond = 1'b0;
        endcase
    end

    // ALU, exception detection and new-flag computation from the captured operands.
    always_comb begin
        res   = '0;
        exc_c = 1'b0;
        cnd_c = 1'b0;
        of_c  = 1'b0;
        cc_we = 1'b0;
        case (icode_q)
            4'h0, 4'h1, 4'h7: res = '0;
            4'h2:             res = vala_q;
            4'h3:             res = valc_q;
            4'h4, 4'h5:       res = valb_q + valc_q;
            4'h6: begin
                cc_we = 1'b1;
                case (ifun_q)
                    4'd0: begin
                        res  = valb_q + vala_q;
                        of_c = (vala_q[WIDTH-1] == valb_q[WIDTH-1]) &&
                               (res[WIDTH-1] != valb_q[WIDTH-1]);
                    end
                    4'd1: begin
                        res  = valb_q - vala_q;
                        of_c = (vala_q[WIDTH-1] != valb_q[WIDTH-1]) &&
                               (res[WIDTH-1] != valb_q[WIDTH-1]);
                    end
                    4'd2: res = valb_q & vala_q;
                    4'd3: res = valb_q ^ vala_q;
                    default: begin
                        exc_c = 1'b1;
                        cc_we = 1'b0;
                    end
                endcase
            end
            4'h8, 4'hA: res = valb_q - WIDTH'(8);
            4'h9, 4'hB: res = valb_q + WIDTH'(8);
            default:    exc_c = 1'b1;
        endcase
        if ((icode_q == 4'h2) || (icode_q == 4'h7)) begin
            if (ifun_q > 4'd6) exc_c = 1'b1;
            else               cnd_c = cond;
        end
        if (exc_c) begin
            res   = '0;
            cnd_c = 1'b0;
            of_c  = 1'b0;
        end
    end

    // Control FSM with registered outputs; reset discards any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            valE      <= '0;
            Cnd       <= 1'b0;
            exc       <= 1'b0;
            cc        <= 3'b100;
            icode_q   <= '0;
            ifun_q    <= '0;
            vala_q    <= '0;
            valb_q    <= '0;
            valc_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        icode_q <= icode;
                        ifun_q  <= ifun;
                        vala_q  <= valA;
                        valb_q  <= valB;
                        valc_q  <= valC;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    valE      <= res;
                    Cnd       <= cnd_c;
                    exc       <= exc_c;
                    if (cc_we) cc <= {(res == '0), res[WIDTH-1], of_c};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_execute_unit.sv
// Bench for y86_execute_unit: a reference model predicts each result when
// the instruction is accepted; a monitor compares on every output handshake.
module tb_y86_execute_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        Cnd;
    logic [2:0]  cc;
    logic        exc;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 0;  // 0 random, 1 held low, 2 held high
    logic [2:0]  m_cc;
    logic [68:0] exp_q[$];  // {valE, Cnd, exc, cc}

    y86_execute_unit #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .out_valid(out_valid), .out_ready(out_ready), .valE(valE), .Cnd(Cnd),
        .cc(cc), .exc(exc), .fsm_state(fsm_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: Y86 rules written with signed arithmetic on wider values.
    function automatic logic [68:0] model(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
        logic [63:0] e;
        logic        cn, ex, sf, of, zf, lt;
        logic signed [65:0] wide;
        e = 0; cn = 0; ex = 0;
        zf = m_cc[2]; sf = m_cc[1]; of = m_cc[0];
        lt = (sf != of);
        if (ic > 4'hB) ex = 1;
        else if (ic == 4'h6 && fn > 3) ex = 1;
        else if ((ic == 4'h2 || ic == 4'h7) && fn > 6) ex = 1;
        if (!ex) begin
            if (ic == 4'h2 || ic == 4'h7) begin
                case (fn)
                    0: cn = 1;
                    1: cn = lt || zf;
                    2: cn = lt;
                    3: cn = zf;
                    4: cn = !zf;
                    5: cn = !lt;
                    default: cn = !lt && !zf;
                endcase
            end
            case (ic)
                4'h2: e = a;
                4'h3: e = c;
                4'h4, 4'h5: e = b + c;
                4'h8, 4'hA: e = b - 64'd8;
                4'h9, 4'hB: e = b + 64'd8;
                4'h6: begin
                    of = 0;
                    if (fn == 0) begin
                        wide = $signed({{2{b[63]}}, b}) + $signed({{2{a[63]}}, a});
                        e = wide[63:0];
                        of = (wide > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -66'sh0_8000_0000_0000_0000);
                    end else if (fn == 1) begin
                        wide = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
                        e = wide[63:0];
                        of = (wide > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -66'sh0_8000_0000_0000_0000);
                    end else if (fn == 2) e = b & a;
                    else e = b ^ a;
                    m_cc = {(e == 0), e[63], of};
                end
                default: e = 0;
            endcase
        end
        return {e, cn, ex, m_cc};
    endfunction

    // Driver: wait for in_ready, present one instruction, check accept latency.
    task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        @(posedge clk);
        exp_q.push_back(model(ic, fn, a, b, c));
        #1 in_valid = 0;
        @(negedge clk);
        chk("exec_out_valid", {68'd0, out_valid}, 0);
        chk("exec_in_ready", {68'd0, in_ready}, 0);
        @(negedge clk);
        chk("latency_out_valid", {68'd0, out_valid}, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 69'(exp_q.size()), 0);
    endtask

    // Reset asserted after a given number of half-cycles past accept (1: EXEC, 3: DONE).
    task automatic reset_mid(input int halves, input string name);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1; icode = 4'h6; ifun = 4'd0; valA = 64'd3; valB = 64'd4; valC = 0;
        @(posedge clk);
        #1 in_valid = 0;
        for (int i = 1; i < halves; i++) #5;
        #1 rst_n = 0;
        #1;
        chk({name, "_out_valid"}, {68'd0, out_valid}, 0);
        chk({name, "_cc"}, {66'd0, cc}, 69'b100);
        chk({name, "_vale"}, {5'd0, valE}, 0);
        @(negedge clk);
        rst_n = 1;
        m_cc = 3'b100;
        @(negedge clk);
        chk({name, "_in_ready"}, {68'd0, in_ready}, 1);
        chk({name, "_no_output"}, {68'd0, out_valid}, 0);
    endtask

    // Downstream ready generator
    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) out_ready = 0;
            else if (ready_mode == 2) out_ready = 1;
            else out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor: compare on every output handshake
    initial begin
        logic [68:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {valE, Cnd, exc, cc}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {valE, Cnd, exc, cc}, e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [63:0] a, b;
        logic [3:0]  ic, fn;
        rst_n = 0; in_valid = 0; icode = 0; ifun = 0; valA = 0; valB = 0; valC = 0;
        m_cc = 3'b100;
        #12;
        chk("reset_out_valid", {68'd0, out_valid}, 0);
        chk("reset_in_ready", {68'd0, in_ready}, 1);
        chk("reset_outputs", {valE, Cnd, exc, cc}, {64'd0, 1'b0, 1'b0, 3'b100});
        @(negedge clk);
        rst_n = 1;

        send(4'h6, 4'd3, 64'hAAAAAAAAAAAAAAAA, 64'hCCCCCCCCCCCCCCCC, 0);
        chk("xor_vale", {5'd0, valE}, {5'd0, 64'h6666666666666666});
        chk("xor_cc", {66'd0, cc}, 69'b000);

        send(4'h6, 4'd0, 64'd1, 64'h7FFFFFFFFFFFFFFF, 0);
        chk("addov_vale", {5'd0, valE}, {5'd0, 64'h8000000000000000});
        chk("addov_cc", {66'd0, cc}, 69'b011);
        send(4'h7, 4'd2, 0, 0, 64'h40);
        chk("jl_cnd", {68'd0, Cnd}, 0);

        send(4'h6, 4'd1, 64'd5, 64'd5, 0);
        chk("subeq_vale", {5'd0, valE}, 0);
        chk("subeq_cc", {66'd0, cc}, 69'b100);
        send(4'h7, 4'd3, 0, 0, 0);
        chk("je_cnd", {68'd0, Cnd}, 1);
        chk("je_cc", {66'd0, cc}, 69'b100);
        send(4'h2, 4'd4, 64'h1234, 0, 0);
        chk("cmovne_vale", {5'd0, valE}, {5'd0, 64'h1234});
        chk("cmovne_cnd", {68'd0, Cnd}, 0);

        drain();
        ready_mode = 1;
        send(4'hA, 4'd0, 0, 64'h100, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vale", {5'd0, valE}, {5'd0, 64'hF8});
            chk("bp_out_valid", {68'd0, out_valid}, 1);
            chk("bp_in_ready", {68'd0, in_ready}, 0);
            @(negedge clk);
        end
        ready_mode = 0;
        send(4'hB, 4'd0, 0, 64'hF8, 0);
        chk("pop_vale", {5'd0, valE}, {5'd0, 64'h100});

        send(4'hC, 4'd0, 64'd1, 64'd2, 64'd3);
        chk("illegal_icode", {valE, Cnd, exc, cc}, {64'd0, 1'b0, 1'b1, 3'b100});
        send(4'h6, 4'd4, 64'd1, 64'd2, 0);
        chk("illegal_opq_exc", {68'd0, exc}, 1);
        chk("illegal_opq_vale", {5'd0, valE}, 0);

        ready_mode = 2;
        send(4'h6, 4'd3, 64'd1, 64'd2, 0);
        drain();
        reset_mid(1, "rst_exec");
        ready_mode = 1;
        send(4'h6, 4'd3, 64'd1, 64'd2, 0);
        exp_q.delete();
        reset_mid(3, "rst_done");
        exp_q.delete();
        m_cc = 3'b100;
        ready_mode = 0;

        for (int n = 0; n < 200; n++) begin
            ic = 4'($urandom_range(0, 15));
            fn = 4'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: a = b;
                1: a = 64'h8000000000000000;
                2: b = 64'h7FFFFFFFFFFFFFFF;
                default: ;
            endcase
            send(ic, fn, a, b, {$urandom, $urandom});
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
